// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - shared types and constants for the memory dump controller
package dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_REQ,
        RD_WAIT,
        SEND,
        FIN
    } dump_state_t;

    localparam int HDR_BYTES  = 8;
    localparam int WORD_BYTES = 4;

    // Tracker reset values: min above max marks an untouched memory window.
    localparam logic [31:0] EMPTY_MIN = 32'hFFFF_FFFF;
    localparam logic [31:0] EMPTY_MAX = 32'h0000_0000;

endpackage

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - emits a loaded 32-bit word as 4 bytes LSB-first
module word_byte_serializer
    import dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        ready,
    output logic [7:0]  data,
    output logic        valid,
    output logic        last
);

    logic [31:0] shreg;
    logic [1:0]  idx;
    logic        active;
    logic        accept;

    assign accept = active & ready;
    assign last   = accept & (idx == 2'(WORD_BYTES - 1));
    assign data   = shreg[7:0];
    assign valid  = active;

    // Shifting on every accept leaves the register cleared once the word is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (load) begin
            shreg  <= word;
            idx    <= '0;
            active <= 1'b1;
        end else if (accept) begin
            shreg <= shreg >> 8;
            idx   <= idx + 2'd1;
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/memory_dump_controller.sv
// rtl/memory_dump_controller.sv - streams the dirty data-memory window as a framed byte stream
module memory_dump_controller
    import dump_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] min_addr_i,
    input  logic [ADDR_W-1:0] max_addr_i,
    output logic              mem_owner_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [ADDR_W-1:0] mem_rd_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, count_q, remain_q;
    logic              hdr_second_q;
    logic [1:0]        wait_cnt_q;

    logic              range_empty;
    logic [ADDR_W-1:0] start_base, start_count;
    logic              load;
    logic [31:0]       load_word;
    logic              ser_last;

    assign range_empty = min_addr_i > max_addr_i;
    assign start_base  = range_empty ? '0 : (min_addr_i & ALIGN_MASK);
    assign start_count = range_empty ? '0
                       : (((max_addr_i & ALIGN_MASK) - start_base) >> 2) + ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_word = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load      = 1'b1;
                    load_word = start_base;
                    state_d   = HDR;
                end
            end
            HDR: begin
                // Header goes out as two serializer loads: base, then count.
                if (ser_last) begin
                    if (!hdr_second_q) begin
                        load      = 1'b1;
                        load_word = count_q;
                    end else begin
                        state_d = (count_q == '0) ? FIN : RD_REQ;
                    end
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: begin
                if (wait_cnt_q == 2'(RD_LATENCY - 1)) begin
                    load      = 1'b1;
                    load_word = mem_rd_data_i;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // Termination follows the word counter so address wrap is harmless.
                if (ser_last) begin
                    state_d = (remain_q == ADDR_W'(1)) ? FIN : RD_REQ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            remain_q     <= '0;
            hdr_second_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q       <= start_base;
                        count_q      <= start_count;
                        remain_q     <= start_count;
                        hdr_second_q <= 1'b0;
                    end
                end
                HDR: begin
                    if (ser_last) begin
                        hdr_second_q <= 1'b1;
                    end
                end
                RD_REQ:  wait_cnt_q <= '0;
                RD_WAIT: wait_cnt_q <= wait_cnt_q + 2'd1;
                SEND: begin
                    if (ser_last) begin
                        addr_q   <= addr_q + ADDR_W'(4);
                        remain_q <= remain_q - ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    word_byte_serializer u_serializer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .word  (load_word),
        .ready (tx_ready_i),
        .data  (tx_data_o),
        .valid (tx_valid_o),
        .last  (ser_last)
    );

    assign busy_o      = (state_q != IDLE);
    assign mem_owner_o = (state_q != IDLE);
    assign mem_rd_en_o = (state_q == RD_REQ);
    assign mem_addr_o  = addr_q;
    assign done_o      = (state_q == FIN);

endmodule
